// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the next-PC unit of the multicycle MIPS datapath:
// FSM state encoding, default reset/exception vectors, the canonical
// candidate-source indices and a small alignment helper.
// ---------------------------------------------------------------------------
package pc_pkg;

    typedef enum logic {
        PC_IDLE    = 1'b0,
        PC_PENDING = 1'b1
    } pc_state_e;

    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] PC_EXC_VECTOR   = 32'h0000_00FF;

    localparam int SRC_PC4    = 0;
    localparam int SRC_ALU    = 1;
    localparam int SRC_EPC    = 2;
    localparam int SRC_MDR    = 3;
    localparam int SRC_ALUOUT = 4;
    localparam int SRC_JUMP   = 5;
    localparam int SRC_REGA   = 7;

    // Instruction addresses must be word aligned.
    function automatic logic isMisaligned(input logic [1:0] addrLsbs);
        return addrLsbs != 2'b00;
    endfunction

endpackage

// File: rtl/pc_source_unit_if.sv
// ---------------------------------------------------------------------------
// pc_source_unit_if
// Bundles the datapath-facing signals of the next-PC unit.
//   master : drives the candidate sources and control, observes the PC state
//   slave  : the PC unit itself
// Signals:
//   src_data       packed candidate addresses, source i = [i*WIDTH +: WIDTH]
//   src_sel        candidate index
//   pc_write       unconditional update request
//   pc_write_cond  conditional update request, qualified by branch_taken
//   exc_req        external exception request
//   stall          fetch stalled, PC must not move
//   pc_out         current PC
//   epc_out        PC captured at the last exception or fault
//   misaligned     one-cycle pulse on alignment fault
//   sel_error      one-cycle pulse on out-of-range select
//   pending        redirect buffered
// ---------------------------------------------------------------------------
interface pc_source_unit_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 8,
    parameter int SEL_W   = $clog2(NUM_SRC)
);

    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic [SEL_W-1:0]         src_sel;
    logic                     pc_write;
    logic                     pc_write_cond;
    logic                     branch_taken;
    logic                     exc_req;
    logic                     stall;
    logic [WIDTH-1:0]         pc_out;
    logic [WIDTH-1:0]         epc_out;
    logic                     misaligned;
    logic                     sel_error;
    logic                     pending;

    modport master (
        output src_data, src_sel, pc_write, pc_write_cond, branch_taken,
               exc_req, stall,
        input  pc_out, epc_out, misaligned, sel_error, pending
    );

    modport slave (
        input  src_data, src_sel, pc_write, pc_write_cond, branch_taken,
               exc_req, stall,
        output pc_out, epc_out, misaligned, sel_error, pending
    );

endinterface

// File: rtl/pc_src_select.sv
// ---------------------------------------------------------------------------
// pc_src_select
// Purely combinational N:1 selector over a packed bus of candidate
// addresses.
// Ports:
//   src_data_i  packed candidates, source i = [i*WIDTH +: WIDTH]
//   src_sel_i   candidate index
//   target_o    selected candidate, zero when the index is out of range
//   in_range_o  high when src_sel_i < NUM_SRC
// ---------------------------------------------------------------------------
module pc_src_select #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 8,
    parameter int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC*WIDTH-1:0] src_data_i,
    input  logic [SEL_W-1:0]         src_sel_i,
    output logic [WIDTH-1:0]         target_o,
    output logic                     in_range_o
);

    // An out-of-range index yields zero so it can never look misaligned;
    // the select error then takes over in the priority chain.
    always_comb begin
        target_o   = '0;
        in_range_o = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_sel_i == SEL_W'(i)) begin
                target_o   = src_data_i[i*WIDTH +: WIDTH];
                in_range_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pc_source_unit.sv
// ---------------------------------------------------------------------------
// pc_source_unit
// Registered next-PC unit: selects a candidate address, qualifies the write
// with unconditional/conditional-branch control, redirects on exceptions and
// alignment faults, and buffers one redirect while fetch is stalled.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low
//   bus    pc_source_unit_if.slave (sources, control, PC/EPC and status)
// ---------------------------------------------------------------------------
module pc_source_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter int               NUM_SRC      = 8,
    parameter int               SEL_W        = $clog2(NUM_SRC),
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(PC_EXC_VECTOR)
) (
    input  logic            clk,
    input  logic            reset,
    pc_source_unit_if.slave bus
);

    logic [WIDTH-1:0] target;
    logic             inRange;
    logic             req;
    logic             alignFault;
    logic             selFault;
    logic             takeExc;

    pc_state_e        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             mis_q, mis_d;
    logic             selerr_q, selerr_d;

    pc_src_select #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_select (
        .src_data_i (bus.src_data),
        .src_sel_i  (bus.src_sel),
        .target_o   (target),
        .in_range_o (inRange)
    );

    // Both write requests share one target, so they collapse into one req.
    // Fault terms are already masked by higher-priority events.
    always_comb begin
        req        = bus.pc_write | (bus.pc_write_cond & bus.branch_taken);
        alignFault = req & isMisaligned(target[1:0]) & ~bus.exc_req;
        selFault   = req & ~inRange & ~bus.exc_req & ~alignFault;
        takeExc    = bus.exc_req | alignFault;
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= PC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a select error leaves any buffered redirect untouched
    always_comb begin
        state_d = state_q;
        if (takeExc) begin
            state_d = PC_IDLE;
        end else if (selFault) begin
            state_d = state_q;
        end else if (req) begin
            state_d = bus.stall ? PC_PENDING : PC_IDLE;
        end else if (!bus.stall) begin
            state_d = PC_IDLE;
        end
    end

    // FSM outputs
    always_comb begin
        bus.pending = (state_q == PC_PENDING);
    end

    // Datapath next values. Exceptions and alignment faults ignore stall;
    // the buffer is only meaningful while the FSM is in PENDING.
    always_comb begin
        pc_d     = pc_q;
        epc_d    = epc_q;
        buf_d    = buf_q;
        mis_d    = 1'b0;
        selerr_d = 1'b0;
        if (takeExc) begin
            pc_d  = EXC_VECTOR;
            epc_d = pc_q;
            mis_d = alignFault;
        end else if (selFault) begin
            selerr_d = 1'b1;
        end else if (req) begin
            if (bus.stall) begin
                buf_d = target;
            end else begin
                pc_d = target;
            end
        end else if ((state_q == PC_PENDING) && !bus.stall) begin
            pc_d = buf_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q     <= RESET_VECTOR;
            epc_q    <= '0;
            buf_q    <= '0;
            mis_q    <= 1'b0;
            selerr_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            epc_q    <= epc_d;
            buf_q    <= buf_d;
            mis_q    <= mis_d;
            selerr_q <= selerr_d;
        end
    end

    always_comb begin
        bus.pc_out     = pc_q;
        bus.epc_out    = epc_q;
        bus.misaligned = mis_q;
        bus.sel_error  = selerr_q;
    end

endmodule

// File: doc/pc_source_unit.md
# pc_source_unit

Parametrised, registered next-PC unit for the multicycle MIPS datapath. Selects one of `NUM_SRC` candidate addresses (PC+4, ALU, EPC, memory data, ALUOut, jump target, register A, …), qualifies the write by unconditional/conditional-branch control, and owns the PC register. It adds exception redirect, alignment checking and a one-entry pending-redirect buffer for stalls. Sits between the datapath source buses and instruction fetch; `epc_out` feeds the EPC path.

## Interface
Parameters:
- `WIDTH`, 32, address width in bits (≥ 8).
- `NUM_SRC`, 8, number of candidate sources (2..16).
- `SEL_W`, `$clog2(NUM_SRC)`, select width.
- `RESET_VECTOR`, 32'h0000_0000, PC value after reset.
- `EXC_VECTOR`, 32'h0000_00FF, PC value loaded on exception/fault.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low. Asserted low clears state immediately.
- `src_data` in `NUM_SRC*WIDTH`: packed sources; source *i* = bits `[i*WIDTH +: WIDTH]`.
- `src_sel` in `SEL_W`: source index.
- `pc_write` in 1: unconditional update request.
- `pc_write_cond` in 1: conditional update request.
- `branch_taken` in 1: qualifies `pc_write_cond`.
- `exc_req` in 1: external exception request.
- `stall` in 1: fetch stalled; PC must not change.
- `pc_out` out `WIDTH`: current PC register.
- `epc_out` out `WIDTH`: PC captured at the last exception/fault.
- `misaligned` out 1: one-cycle pulse on alignment fault.
- `sel_error` out 1: one-cycle pulse on out-of-range `src_sel`.
- `pending` out 1: high while a redirect is buffered.

## Operation
- `req = pc_write | (pc_write_cond & branch_taken)`. `target = src_data[src_sel]`.
- Priority, highest first, evaluated each cycle:
  1. `exc_req`
  2. misaligned (`req & target[1:0] != 0`)
  3. `sel_error` (`req & src_sel ≥ NUM_SRC`)
  4. `req`
  5. buffered pending target
- `exc_req` (ignores `stall`): `pc_out ← EXC_VECTOR`, `epc_out ← pc_out`, pending buffer cleared.
- Misaligned (ignores `stall`): same load as `exc_req`; `misaligned` pulses.
- `sel_error`: PC holds, `sel_error` pulses, buffer unchanged.
- Valid `req` with `stall=0`: `pc_out ← target`, buffer cleared.
- Valid `req` with `stall=1`: `target` is written into the buffer, overwriting any older entry (newest wins). PC holds.
- No `req`, `stall=0`, buffer full: `pc_out ← buffered target`, buffer cleared.
- FSM `IDLE`/`PENDING`:
  - `IDLE→PENDING` on valid `req` while stalled.
  - `PENDING→IDLE` on drain, exception or fault.
  - `PENDING` stays on further stalls.
- `pending` = (state == `PENDING`).

## Timing
- Reset values: `pc_out=RESET_VECTOR`, `epc_out=0`, `misaligned=0`, `sel_error=0`, `pending=0`, state `IDLE`.
- Latency: one cycle from a qualified request to `pc_out` change. Pulses are registered and coincide with the resulting `pc_out` update.
- Buffered target appears on `pc_out` the edge after the first cycle with `stall=0`.
- `exc_req` and a valid `req` in the same cycle: the exception wins and `req` is dropped.
- Reset asserted mid-`PENDING`: buffer is discarded and the PC goes to `RESET_VECTOR`.
- `pc_write` and `pc_write_cond` both high: treated as one request with the same target.

## Structure
- Shared package `pc_pkg` holds:
  - state encoding `PC_IDLE=1'b0`, `PC_PENDING=1'b1`;
  - default vectors;
  - source index constants `SRC_PC4=0`, `SRC_ALU=1`, `SRC_EPC=2`, `SRC_MDR=3`, `SRC_ALUOUT=4`, `SRC_JUMP=5`, `SRC_REGA=7`.
- Sub-module `pc_src_select`: purely combinational N:1 packed-bus selector. It outputs `target` and an in-range flag.
- The top level holds the FSM, the buffer and the PC/EPC registers.

## Test plan
1. Reset release → `pc_out=0`. Then `pc_write=1`, `src_sel=1`, ALU=32'h0000_0040 → `pc_out=32'h40` after one edge.
2. `pc_write_cond=1`, `branch_taken=0` → PC holds. Repeat with `branch_taken=1`, ALUOut=32'h100 → `pc_out=32'h100`.
3. `stall=1` with `pc_write` to 32'h200, then 32'h300 the next cycle, then `stall=0` → `pending=1` for 2 cycles, then `pc_out=32'h300` and `pending=0`.
4. `pc_out=32'h80`, `pc_write` with target 32'h202 → `pc_out=32'hFF`, `epc_out=32'h80`, `misaligned` pulses once.
5. `NUM_SRC=6`, `src_sel=7` with `pc_write` → PC holds, `sel_error` pulses once. Then `exc_req` together with a valid `req` → `pc_out=EXC_VECTOR`.
6. While `pending=1`, drive `reset` low asynchronously → `pc_out=0` and `pending=0` without waiting for a clock edge.
